// File: rtl/dac_arb.sv
// Round-robin arbiter that shares one SPI DAC serializer among NREQ requesters,
// enforcing a chip-select idle gap between transfers and a timeout on a hung serializer.
module dac_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 10,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                    s_clk,
  input  logic                    s_rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic                    req_err,
  output logic                    dac_start,
  output logic [DW-1:0]           dac_data,
  input  logic                    dac_busy,
  input  logic                    dac_done,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]    GAP_LOAD = 8'(GAP_CYC);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  logic [1:0]      state;
  logic [GW-1:0]   ptr;
  logic [7:0]      gap_cnt;
  logic [TW-1:0]   to_cnt;
  logic            err;
  logic            mask_last;

  logic [DW-1:0]   codes [NREQ];
  logic [NREQ-1:0] masked;
  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   cand;

  for (genvar i = 0; i < NREQ; i++) begin : g_codes
    assign codes[i] = req_data[i*DW +: DW];
  end

  // The requester just acked is hidden for one cycle so a lingering req
  // cannot win again when there is no idle gap.
  always_comb begin
    masked = req;
    if (mask_last) masked[grant_id] = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = GW'((int'(ptr) + k) % NREQ);
      if (!win_found && masked[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      err       <= 1'b0;
      mask_last <= 1'b0;
      grant_id  <= '0;
      dac_data  <= '0;
    end else begin
      mask_last <= (state == ACK);
      case (state)
        IDLE: begin
          if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
          if (win_found && gap_cnt == 8'd0 && !dac_busy) begin
            grant_id <= win_idx;
            dac_data <= codes[win_idx];
            state    <= START;
          end
        end
        START: begin
          to_cnt <= '0;
          err    <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (dac_done) begin
            err   <= 1'b0;
            state <= ACK;
          end else if (to_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= ACK;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ACK: begin
          ptr     <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          gap_cnt <= GAP_LOAD;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dac_start = (state == START);
  assign busy      = (state != IDLE);
  assign req_err   = (state == ACK) && err;

  always_comb begin
    req_ack = '0;
    if (state == ACK) req_ack[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_dac_arb.sv
// Self-checking bench for dac_arb: scoreboard of expected grants popped on each ack,
// plus a second instance with no idle gap to exercise the regrant mask.
module tb_dac_arb;

  typedef struct {
    logic [1:0] id;
    logic [9:0] data;
    logic       err;
  } exp_t;

  logic        s_clk;
  logic        s_rst;
  logic [3:0]  req;
  logic [39:0] req_data;
  logic [3:0]  req_ack;
  logic        req_err;
  logic        dac_start;
  logic [9:0]  dac_data;
  logic        dac_busy;
  logic        dac_done = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  req_z;
  logic [39:0] req_data_z;
  logic [3:0]  req_ack_z;
  logic        req_err_z;
  logic        dac_start_z;
  logic [9:0]  dac_data_z;
  logic        dac_busy_z;
  logic        dac_done_z = 1'b0;
  logic [1:0]  grant_id_z;
  logic        busy_z;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cnt = 0;
  int   last_start_cyc = 0;
  int   countdown = 0;
  bit   hang = 1'b0;
  logic [9:0] codes [4];
  exp_t exp_q [$];

  dac_arb #(.NREQ(4), .DW(10), .GAP_CYC(4), .TIMEOUT(256)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .req(req), .req_data(req_data),
    .req_ack(req_ack), .req_err(req_err), .dac_start(dac_start),
    .dac_data(dac_data), .dac_busy(dac_busy), .dac_done(dac_done),
    .grant_id(grant_id), .busy(busy)
  );

  dac_arb #(.NREQ(4), .DW(10), .GAP_CYC(0), .TIMEOUT(256)) dut_z (
    .s_clk(s_clk), .s_rst(s_rst), .req(req_z), .req_data(req_data_z),
    .req_ack(req_ack_z), .req_err(req_err_z), .dac_start(dac_start_z),
    .dac_data(dac_data_z), .dac_busy(dac_busy_z), .dac_done(dac_done_z),
    .grant_id(grant_id_z), .busy(busy_z)
  );

  initial s_clk = 1'b0;
  always #10 s_clk = ~s_clk;

  always @(posedge s_clk) cyc++;

  // Serializer model: done pulse 16 cycles after start unless hung.
  always @(negedge s_clk) begin
    dac_done = 1'b0;
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) dac_done = 1'b1;
    end
    if (dac_start === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (!hang) countdown = 16;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: sim time expired, bad=%0d", bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge s_clk);
    #1;
  endtask

  task automatic wait_ack(input int limit, output bit seen, output int at);
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge s_clk);
      if (req_ack !== 4'b0000) begin
        seen = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic apply_reset;
    s_rst = 1'b1;
    req = 4'b0000;
    req_z = 4'b0000;
    repeat (2) tick;
    s_rst = 1'b0;
  endtask

  task automatic test_reset;
    s_rst = 1'b1;
    req = 4'b0000;
    req_z = 4'b0000;
    tick;
    @(negedge s_clk);
    total++;
    if ({req_ack, req_err, dac_start} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctl: ack=%b err=%b start=%b, want 0", req_ack, req_err, dac_start);
    end
    total++;
    if ({dac_data, grant_id, busy} !== 13'b0) begin
      bad++;
      $display("[TB] FAIL reset_data: data=%h gid=%0d busy=%b, want 0", dac_data, grant_id, busy);
    end
    total++;
    if ({req_ack_z, req_err_z, dac_start_z, dac_data_z, grant_id_z, busy_z} !== 19'b0) begin
      bad++;
      $display("[TB] FAIL reset_z: ack=%b start=%b data=%h busy=%b, want 0",
               req_ack_z, dac_start_z, dac_data_z, busy_z);
    end
    tick;
    s_rst = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    bit   seen;
    int   ack_at;
    int   st_at;
    tick;
    req = 4'b0001;
    exp_q.push_back('{id: 2'd0, data: codes[0], err: 1'b0});
    @(negedge s_clk);
    total++;
    if (dac_start !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_early: start=%b, want 0", dac_start);
    end
    @(negedge s_clk);
    st_at = cyc;
    total++;
    if (dac_start !== 1'b1 || dac_data !== 10'h2A5 || grant_id !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_start: start=%b data=%h gid=%0d busy=%b, want 1/2a5/0/1",
               dac_start, dac_data, grant_id, busy);
    end
    wait_ack(40, seen, ack_at);
    e = exp_q.pop_front();
    total++;
    if (!seen || req_ack !== (4'b0001 << e.id) || req_err !== e.err || dac_data !== e.data) begin
      bad++;
      $display("[TB] FAIL single_ack: seen=%b ack=%b err=%b data=%h, want %b/%b/%h",
               seen, req_ack, req_err, dac_data, 4'b0001 << e.id, e.err, e.data);
    end
    total++;
    if (ack_at - st_at !== 17) begin
      bad++;
      $display("[TB] FAIL single_latency: start->ack=%0d, want 17", ack_at - st_at);
    end
    tick;
    req = 4'b0000;
    @(negedge s_clk);
    total++;
    if (busy !== 1'b0 || req_ack !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL single_release: busy=%b ack=%b, want 0/0", busy, req_ack);
    end
  endtask

  task automatic test_round_robin;
    exp_t       e;
    bit         seen;
    int         ack_at;
    int         s0;
    logic [1:0] id;
    apply_reset;
    s0 = start_cnt;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back('{id: 2'(k % 4), data: codes[k % 4], err: 1'b0});
      wait_ack(80, seen, ack_at);
      e = exp_q.pop_front();
      total++;
      if (!seen || req_ack !== (4'b0001 << e.id) || grant_id !== e.id ||
          dac_data !== e.data || req_err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rr_grant%0d: seen=%b ack=%b gid=%0d data=%h, want gid=%0d data=%h",
                 k, seen, req_ack, grant_id, dac_data, e.id, e.data);
      end
      id = e.id;
      tick;
      req[id] = 1'b0;
      tick;
      req[id] = 1'b1;
    end
    tick;
    req = 4'b0000;
    total++;
    if (start_cnt - s0 !== 5) begin
      bad++;
      $display("[TB] FAIL rr_starts: starts=%0d, want 5", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit   seen;
    int   a1;
    int   a2;
    apply_reset;
    req = 4'b0011;
    exp_q.push_back('{id: 2'd0, data: codes[0], err: 1'b0});
    exp_q.push_back('{id: 2'd1, data: codes[1], err: 1'b0});
    wait_ack(40, seen, a1);
    e = exp_q.pop_front();
    total++;
    if (!seen || req_ack !== (4'b0001 << e.id) || dac_data !== e.data) begin
      bad++;
      $display("[TB] FAIL b2b_first: seen=%b ack=%b data=%h, want %b/%h",
               seen, req_ack, dac_data, 4'b0001 << e.id, e.data);
    end
    tick;
    req[0] = 1'b0;
    @(negedge s_clk);
    total++;
    if (dac_data !== codes[0]) begin
      bad++;
      $display("[TB] FAIL b2b_hold: data=%h, want %h", dac_data, codes[0]);
    end
    wait_ack(60, seen, a2);
    e = exp_q.pop_front();
    total++;
    if (!seen || req_ack !== (4'b0001 << e.id) || grant_id !== e.id || dac_data !== e.data) begin
      bad++;
      $display("[TB] FAIL b2b_second: seen=%b ack=%b gid=%0d data=%h, want gid=%0d data=%h",
               seen, req_ack, grant_id, dac_data, e.id, e.data);
    end
    total++;
    if (last_start_cyc - a1 !== 6) begin
      bad++;
      $display("[TB] FAIL b2b_gap: ack->start=%0d, want 6", last_start_cyc - a1);
    end
    tick;
    req = 4'b0000;
  endtask

  task automatic test_no_gap_mask;
    bit   seen;
    logic regrant;
    seen = 1'b0;
    tick;
    req_z = 4'b0001;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge s_clk);
      if (dac_start_z === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || dac_data_z !== codes[0]) begin
      bad++;
      $display("[TB] FAIL nogap_start: seen=%b data=%h, want 1/%h", seen, dac_data_z, codes[0]);
    end
    repeat (3) @(negedge s_clk);
    dac_done_z = 1'b1;
    @(negedge s_clk);
    dac_done_z = 1'b0;
    total++;
    if (req_ack_z !== 4'b0001 || req_err_z !== 1'b0) begin
      bad++;
      $display("[TB] FAIL nogap_ack: ack=%b err=%b, want 0001/0", req_ack_z, req_err_z);
    end
    tick;
    tick;
    req_z = 4'b0000;
    regrant = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge s_clk);
      regrant = regrant | dac_start_z | busy_z;
    end
    total++;
    if (regrant !== 1'b0) begin
      bad++;
      $display("[TB] FAIL nogap_regrant: start/busy seen=%b, want 0", regrant);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    bit   seen;
    int   g;
    int   ack_at;
    hang = 1'b1;
    tick;
    req = 4'b1100;
    g = cyc;
    exp_q.push_back('{id: 2'd2, data: codes[2], err: 1'b1});
    exp_q.push_back('{id: 2'd3, data: codes[3], err: 1'b0});
    wait_ack(300, seen, ack_at);
    hang = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (!seen || req_ack !== (4'b0001 << e.id) || req_err !== e.err) begin
      bad++;
      $display("[TB] FAIL timeout_ack: seen=%b ack=%b err=%b, want %b/%b",
               seen, req_ack, req_err, 4'b0001 << e.id, e.err);
    end
    total++;
    if (ack_at - g !== 258) begin
      bad++;
      $display("[TB] FAIL timeout_cycle: grant->ack=%0d, want 258", ack_at - g);
    end
    tick;
    req[2] = 1'b0;
    wait_ack(60, seen, ack_at);
    e = exp_q.pop_front();
    total++;
    if (!seen || req_ack !== (4'b0001 << e.id) || req_err !== e.err || dac_data !== e.data) begin
      bad++;
      $display("[TB] FAIL timeout_next: seen=%b ack=%b err=%b data=%h, want %b/%b/%h",
               seen, req_ack, req_err, dac_data, 4'b0001 << e.id, e.err, e.data);
    end
    tick;
    req = 4'b0000;
  endtask

  task automatic test_busy_stall_reset;
    exp_t e;
    bit   seen;
    int   ack_at;
    int   s0;
    int   f;
    dac_busy = 1'b1;
    tick;
    req = 4'b0100;
    s0 = start_cnt;
    exp_q.push_back('{id: 2'd2, data: codes[2], err: 1'b0});
    repeat (10) @(negedge s_clk);
    total++;
    if (start_cnt !== s0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_hold: starts=%0d busy=%b, want 0/0", start_cnt - s0, busy);
    end
    tick;
    dac_busy = 1'b0;
    f = cyc;
    wait_ack(40, seen, ack_at);
    e = exp_q.pop_front();
    total++;
    if (!seen || req_ack !== (4'b0001 << e.id) || dac_data !== e.data) begin
      bad++;
      $display("[TB] FAIL stall_ack: seen=%b ack=%b data=%h, want %b/%h",
               seen, req_ack, dac_data, 4'b0001 << e.id, e.data);
    end
    total++;
    if (last_start_cyc - f !== 1) begin
      bad++;
      $display("[TB] FAIL stall_release: release->start=%0d, want 1", last_start_cyc - f);
    end
    tick;
    req = 4'b0000;
    tick;
    req = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge s_clk);
      if (dac_start === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || grant_id !== 2'd1) begin
      bad++;
      $display("[TB] FAIL abort_start: seen=%b gid=%0d, want 1/1", seen, grant_id);
    end
    repeat (3) tick;
    s_rst = 1'b1;
    req = 4'b0000;
    tick;
    s_rst = 1'b0;
    @(negedge s_clk);
    total++;
    if ({req_ack, req_err, dac_start, dac_data, grant_id, busy} !== 19'b0) begin
      bad++;
      $display("[TB] FAIL abort_outputs: ack=%b err=%b start=%b data=%h gid=%0d busy=%b, want 0",
               req_ack, req_err, dac_start, dac_data, grant_id, busy);
    end
    wait_ack(30, seen, ack_at);
    total++;
    if (seen) begin
      bad++;
      $display("[TB] FAIL abort_noack: ack=%b at cycle %0d, want none", req_ack, ack_at);
    end
    tick;
    req = 4'b1010;
    exp_q.push_back('{id: 2'd1, data: codes[1], err: 1'b0});
    wait_ack(60, seen, ack_at);
    e = exp_q.pop_front();
    total++;
    if (!seen || req_ack !== (4'b0001 << e.id) || grant_id !== e.id) begin
      bad++;
      $display("[TB] FAIL reset_ptr: seen=%b ack=%b gid=%0d, want %b/%0d",
               seen, req_ack, grant_id, 4'b0001 << e.id, e.id);
    end
    tick;
    req = 4'b0000;
  endtask

  initial begin
    codes[0] = 10'h2A5;
    codes[1] = 10'h13C;
    codes[2] = 10'h0F1;
    codes[3] = 10'h3AA;
    for (int i = 0; i < 4; i++) req_data[i*10 +: 10] = codes[i];
    req_data_z = req_data;
    s_rst = 1'b1;
    req = 4'b0000;
    req_z = 4'b0000;
    dac_busy = 1'b0;
    dac_busy_z = 1'b0;

    $display("[TB] starting dac_arb bench");
    test_reset;
    test_single;
    test_round_robin;
    test_back_to_back;
    test_no_gap_mask;
    test_timeout;
    test_busy_stall_reset;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_arb.md
# dac_arb

Round-robin arbiter and transfer sequencer that shares the single SPI DAC serializer among up to NREQ independent data sources. It sits between the data producers and the serializer (the 50 MHz-to-12.5 MHz SPI shifter). It accepts req/ack requests carrying a DW-bit DAC code and issues one serializer transfer at a time. It enforces a minimum chip-select idle gap between transfers and recovers from a hung serializer by timeout.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 10, DAC code width
- GAP_CYC, 4, minimum s_clk cycles between ACK and the next grant (0..255)
- TIMEOUT, 256, max s_clk cycles waiting for dac_done (≥ 2)

Ports:
- s_clk  in  1  system clock, 50 MHz; one clock; all logic on rising edge
- s_rst  in  1  reset: synchronous, active-high
- req  in  NREQ  request level, bit i = requester i
- req_data  in  NREQ*DW  packed codes, requester i at [i*DW +: DW]
- req_ack  out  NREQ  one-cycle completion pulse to the granted requester
- req_err  out  1  one-cycle pulse coincident with req_ack when the transfer timed out
- dac_start  out  1  one-cycle start pulse to serializer
- dac_data  out  DW  code to serializer, held stable from START until the next grant
- dac_busy  in  1  serializer busy (transfer in progress)
- dac_done  in  1  one-cycle pulse from serializer at end of transfer
- grant_id  out  clog2(NREQ)  index of current/last granted requester
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, START, WAIT, ACK. Outputs are Moore/registered.
- IDLE: the block grants when all of the following hold: some req is high after masking, gap_cnt==0, and dac_busy==0.
  - The winner is the first set bit at or above ptr, searching upward with wrap to bit 0.
  - On grant: register grant_id, load dac_data = req_data[winner], go to START.
- START: dac_start=1 for exactly one cycle, then WAIT; clear to_cnt.
- WAIT: on dac_done go to ACK with err=0.
  - Otherwise increment to_cnt; when to_cnt reaches TIMEOUT-1 without dac_done, go to ACK with err=1.
  - dac_done outside WAIT is ignored.
- ACK: req_ack[grant_id]=1 and req_err=err for one cycle; ptr = (grant_id+1) mod NREQ; gap_cnt = GAP_CYC; go to IDLE.
- In the IDLE cycle immediately after ACK, req[grant_id] is masked. This prevents a double grant when GAP_CYC=0 and the requester has not yet dropped req.
- gap_cnt decrements to 0 while in IDLE.
- Requester contract: hold req and req_data stable until req_ack; drop req in the cycle after req_ack.
- A requester that drops req early still gets its transfer completed and acked; req_data is sampled only at grant.
- Reset:
  - state=IDLE, ptr=0, gap_cnt=0, to_cnt=0, err=0.
  - All outputs are 0: req_ack, req_err, dac_start, dac_data, grant_id, busy.
  - An in-flight serializer transfer is not aborted. IDLE waits for dac_busy low before the first grant.

## Timing
- Cycle 0: IDLE, grant conditions true.
- Cycle 1: START; dac_start=1, dac_data and grant_id valid, busy=1.
- Cycle 2 onward: WAIT.
- dac_done seen at cycle D: req_ack pulse at D+1, busy low at D+2.
- Earliest next grant is cycle D+2+GAP_CYC, with dac_start one cycle later.
- Timeout: WAIT entered at cycle 2; ACK with req_err at cycle 2+TIMEOUT.
- Throughput per transfer = serializer time + GAP_CYC + 3 cycles overhead.
- Simultaneous requests: exactly one grant per arbitration. Fairness: each active requester is served within NREQ transfers.
- dac_busy high while in IDLE stalls the grant without losing requests.

## Test plan
- Single request: req=4'b0001, req_data[0]=10'h2A5; serializer returns dac_done 16 cycles after dac_start. Required: dac_start at cycle 1 with dac_data=10'h2A5, req_ack=4'b0001 one cycle after done, req_err=0.
- Round-robin: req=4'b1111 held, each requester re-asserting after its ack. Required: grant order 0,1,2,3,0 and exactly one dac_start per ack.
- Gap enforcement with GAP_CYC=4: back-to-back requests from 0 then 1. Required: second dac_start exactly 6 cycles after the first req_ack (ACK→IDLE + 4 gap + START). With GAP_CYC=0, requester 0 holding req one extra cycle is not regranted.
- Timeout with TIMEOUT=256: dac_done never asserted. Required: req_ack and req_err both high at cycle 258 after grant, then the next requester is served normally.
- Busy stall / reset: hold dac_busy=1 while req=4'b0100. Required: no dac_start until dac_busy falls, then dac_start the cycle after grant. Assert s_rst mid-WAIT. Required: all outputs 0 next cycle, ptr=0, no req_ack issued for the aborted transfer.
